// File: rtl/sram_rw_port_ctrl.sv
// Requester-side controller for a single-port RW0 SRAM: optional post-reset zero fill,
// valid/ready request stream to RW0 accesses, credit-limited in-order read response queue.
module sram_rw_port_ctrl #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 512,
    parameter int RESP_DEPTH    = 3,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int                CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int                PTR_W  = $clog2(RESP_DEPTH);
    localparam logic [CNT_W-1:0]  Q_FULL = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]  P_LAST = PTR_W'(RESP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_ptr, w_init_ptr_nxt;
    logic              r_init_done;
    logic              r_rd_inflight;
    logic [DATA_W-1:0] r_q_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop, w_push, w_accept;
    logic [CNT_W:0]    w_used;

    assign resp_valid = (r_count != '0);
    assign resp_rdata = r_q_mem[r_rd_ptr];
    assign init_done  = r_init_done;
    assign w_pop      = resp_valid && resp_ready;
    assign w_push     = r_rd_inflight;
    // Queued plus in-flight reads are the credits in use; a same-cycle pop frees one.
    assign w_used     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_inflight} - {{CNT_W{1'b0}}, w_pop};
    assign req_ready  = r_init_done && (w_used < {1'b0, Q_FULL});
    assign w_accept   = req_valid && req_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        sram_en        = 1'b0;
        sram_wmode     = 1'b0;
        sram_addr      = req_addr;
        sram_wmask     = req_wmask;
        sram_wdata     = req_wdata;
        case (r_state)
            S_INIT: begin
                // Gated by reset_n so the macro sees no enable while reset is held.
                sram_en    = reset_n;
                sram_wmode = 1'b1;
                sram_addr  = r_init_ptr;
                sram_wmask = '1;
                sram_wdata = '0;
                if (r_init_ptr == A_LAST) w_state_nxt = S_RUN;
                else                      w_init_ptr_nxt = r_init_ptr + 1'b1;
            end
            default: begin
                sram_en    = w_accept;
                sram_wmode = req_write;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= INIT_ON_RESET ? S_INIT : S_RUN;
            r_init_ptr    <= '0;
            r_init_done   <= 1'b0;
            r_rd_inflight <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_init_ptr    <= w_init_ptr_nxt;
            r_init_done   <= (w_state_nxt == S_RUN);
            r_rd_inflight <= w_accept && !req_write;
            if (w_push) r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_q_mem[r_wr_ptr] <= sram_rdata;
    end

    always_ff @(posedge clock) begin
        if (reset_n)
            assert (!(w_push && !w_pop && r_count == Q_FULL))
            else $error("response queue overflow");
    end
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: SRAM macro model, request-level reference model and scoreboard,
// directed scenarios followed by randomized traffic.
module tb_sram_rw_port_ctrl;
    localparam int DEPTH = 512;
    localparam int RD    = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [8:0] req_addr = '0;
    logic [7:0] req_wdata = '0, req_wmask = '0;
    logic       resp_valid, resp_ready = 1'b1;
    logic [7:0] resp_rdata;
    logic       init_done;
    logic       sram_en, sram_wmode;
    logic [8:0] sram_addr;
    logic [7:0] sram_wmask, sram_wdata;
    logic [7:0] sram_rdata = '0;

    sram_rw_port_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // SRAM macro: random power-up contents, registered-address read
    logic [7:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(1, 255));
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: requester-visible array contents and outstanding reads in order
    typedef struct { logic [7:0] d; int cyc; } pend_t;
    pend_t      pend[$];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] got_data[$];
    int         got_lat[$];
    int         since = 0, first_done = 0, n_acc = 0;

    always @(posedge clock) since <= reset_n ? since + 1 : 0;

    always @(negedge clock) begin
        int  c;
        bit  done, exp_v, pop, acc, exp_rdy;
        if (!reset_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_sram_en", sram_en, 0);
            pend.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
            first_done = 0;
        end else begin
            c    = since + 1;
            done = (c >= DEPTH + 1);
            chk("init_done", init_done, done);
            if (!done) begin
                chk("init_en", sram_en, 1);
                chk("init_wmode", sram_wmode, 1);
                chk("init_addr", sram_addr, c - 1);
                chk("init_wdata", sram_wdata, 0);
                chk("init_wmask", sram_wmask, 8'hFF);
            end
            exp_v = (pend.size() > 0) && (pend[0].cyc <= c - 2);
            chk("resp_valid", resp_valid, exp_v);
            if (exp_v) chk("resp_rdata", resp_rdata, pend[0].d);
            pop     = resp_valid && resp_ready;
            exp_rdy = done && ((pend.size() - (pop ? 1 : 0)) < RD);
            chk("req_ready", req_ready, exp_rdy);
            acc = req_valid && req_ready;
            if (done) begin
                chk("run_sram_en", sram_en, acc);
                if (acc) begin
                    chk("run_wmode", sram_wmode, req_write);
                    chk("run_addr", sram_addr, req_addr);
                    if (req_write) begin
                        chk("run_wdata", sram_wdata, req_wdata);
                        chk("run_wmask", sram_wmask, req_wmask);
                    end
                end
            end
            if (pop && pend.size() > 0) begin
                got_data.push_back(resp_rdata);
                got_lat.push_back(c - pend[0].cyc);
                void'(pend.pop_front());
            end
            if (acc) begin
                n_acc++;
                if (req_write) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                else           pend.push_back('{ref_mem[req_addr], c});
            end
            if (init_done && first_done == 0) first_done = c;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic req(input logic w, input logic [8:0] a, input logic [7:0] d, input logic [7:0] m);
        int k = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
        #1;
        while (!req_ready && k < 50) begin @(posedge clock); #1; k++; end
        chk("req_accept_timeout", req_ready, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h155;
        while (!init_done && k < 700) begin @(posedge clock); #1; k++; end
        chk("init_timeout", init_done, 1);
        req_valid = 1'b0;
        cyc(1);
        chk("first_done_cycle", first_done, 513);
    endtask

    initial begin
        int base, gb, k;
        cyc(3);
        reset_n = 1'b1;
        wait_done();

        // Directed: post-init read, write/read, masked write
        req(0, 9'h1FF, 0, 0);
        cyc(3);
        req(1, 9'h0A4, 8'h5A, 8'hFF);
        req(0, 9'h0A4, 0, 0);
        cyc(3);
        req(1, 9'h0A4, 8'h0F, 8'h0C);
        req(0, 9'h0A4, 0, 0);
        cyc(3);
        chk("lit_init_zero", got_data[0], 8'h00);
        chk("lit_wr_rd", got_data[1], 8'h5A);
        chk("lit_wr_rd_lat", got_lat[1], 2);
        chk("lit_masked", got_data[2], 8'h5E);

        // Throughput: 8 back-to-back reads
        for (int i = 0; i < 8; i++) req(1, 9'(9'h10 + i), 8'(8'hA0 + i), 8'hFF);
        cyc(2);
        base = n_acc; gb = got_data.size();
        for (int i = 0; i < 8; i++) req(0, 9'(9'h10 + i), 0, 0);
        cyc(4);
        chk("lit_tput_accepts", n_acc - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk("lit_tput_lat", got_lat[gb + i], 2);
            chk("lit_tput_data", got_data[gb + i], 8'hA0 + i);
        end

        // Backpressure: only RESP_DEPTH reads may be outstanding
        resp_ready = 1'b0;
        base = n_acc; gb = got_data.size();
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 6; i++) begin req_addr = 9'(9'h10 + i); cyc(1); end
        chk("lit_bp_accepts", n_acc - base, 3);
        chk("lit_bp_ready_low", req_ready, 0);
        req_valid = 1'b0; resp_ready = 1'b1;
        cyc(5);
        for (int i = 0; i < 3; i++) chk("lit_bp_data", got_data[gb + i], 8'hA0 + i);
        chk("lit_bp_ready_back", req_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid  = ($urandom % 3) != 0;
            req_write  = $urandom % 2;
            req_addr   = ($urandom % 16 == 0) ? 9'h1FF : 9'($urandom % 16);
            req_wdata  = 8'($urandom);
            req_wmask  = 8'($urandom);
            resp_ready = ($urandom % 4) != 0;
            cyc(1);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        cyc(6);
        chk("drain_empty", pend.size(), 0);

        // Reset in the middle of the init sweep
        reset_n = 1'b0; cyc(3); reset_n = 1'b1;
        req_valid = 1'b1; req_write = 1'b0;
        k = 0;
        while (since != 200 && k < 400) begin cyc(1); k++; end
        chk("mid_init_reach", since, 200);
        reset_n = 1'b0;
        cyc(2);
        chk("mid_rst_done", init_done, 0);
        reset_n = 1'b1;
        wait_done();
        req(0, 9'h010, 0, 0);
        cyc(3);
        chk("lit_reinit_zero", got_data[got_data.size() - 1], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
